// File: rtl/hazard_ctrl_if.sv
// Purpose: bundles decode sources, memory handshakes, redirect and pipeline controls for hazard_ctrl.
// Latency: none; wiring only.
// Backpressure: none; the master drives pipeline status and the slave returns advance/bubble/flush.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             dec_valid;
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic             dec_use_rs1;
  logic             dec_use_rs2;
  logic [4:0]       dec_rd;
  logic             dec_rd_we;
  logic             dec_is_load;
  logic             imem_resp;
  logic             dmem_req;
  logic             dmem_resp;
  logic             ex_redirect;
  logic             adv_fd;
  logic             adv_de;
  logic             adv_back;
  logic             bubble_de;
  logic             flush_fd;
  logic             flush_de;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
    input  dec_rd, dec_rd_we, dec_is_load,
    input  imem_resp, dmem_req, dmem_resp, ex_redirect,
    output adv_fd, adv_de, adv_back, bubble_de, flush_fd, flush_de,
    output stall_cnt, flush_cnt
  );

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
    output dec_rd, dec_rd_we, dec_is_load,
    output imem_resp, dmem_req, dmem_resp, ex_redirect,
    input  adv_fd, adv_de, adv_back, bubble_de, flush_fd, flush_de,
    input  stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose: 5-stage pipeline sequencer: scoreboard-based RAW/load-use stalls, dmem freeze, EX redirect flush.
// Latency: controls are combinational from state + inputs; state, scoreboard and counters update next edge.
// Backpressure: dmem wait freezes every stage; imem wait or hazard holds fetch/decode and bubbles EX.
module hazard_ctrl #(
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_FLUSH} state_t;

  state_t           r_state;
  logic             r_flush_pend;
  logic             r_live;        // low until the first edge after reset release
  logic             r_ex_v, r_mem_v, r_wb_v;
  logic [4:0]       r_ex_rd, r_mem_rd, r_wb_rd;
  logic             r_ex_ld;       // load flag only matters while the producer sits in EX
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_hit_ex, w_hit_mem, w_hit_wb, w_haz, w_dmem_blk;
  logic w_adv_fd, w_adv_de, w_adv_back, w_bubble, w_flush;

  // Source/destination match against each in-flight stage
  always_comb begin
    w_hit_ex   = r_ex_v  & ((bus.dec_use_rs1 & (bus.dec_rs1 == r_ex_rd))  |
                            (bus.dec_use_rs2 & (bus.dec_rs2 == r_ex_rd)));
    w_hit_mem  = r_mem_v & ((bus.dec_use_rs1 & (bus.dec_rs1 == r_mem_rd)) |
                            (bus.dec_use_rs2 & (bus.dec_rs2 == r_mem_rd)));
    w_hit_wb   = r_wb_v  & ((bus.dec_use_rs1 & (bus.dec_rs1 == r_wb_rd))  |
                            (bus.dec_use_rs2 & (bus.dec_rs2 == r_wb_rd)));
    w_haz      = 1'b0;
    if (FWD_EN != 0) w_haz = bus.dec_valid & w_hit_ex & r_ex_ld;
    else             w_haz = bus.dec_valid & (w_hit_ex | w_hit_mem | w_hit_wb);
    w_dmem_blk = bus.dmem_req & ~bus.dmem_resp;
  end

  // Pipeline controls, priority: dmem freeze > redirect > imem wait > data hazard
  always_comb begin
    w_adv_fd   = 1'b0;
    w_adv_de   = 1'b0;
    w_adv_back = 1'b0;
    w_bubble   = 1'b0;
    w_flush    = 1'b0;
    if (r_live) begin
      case (r_state)
        ST_RUN: begin
          if (w_dmem_blk) begin
            // full freeze, nothing moves
          end else if (bus.ex_redirect) begin
            w_flush = 1'b1; w_adv_fd = 1'b1; w_adv_de = 1'b1; w_adv_back = 1'b1;
          end else if (!bus.imem_resp || w_haz) begin
            w_bubble = 1'b1; w_adv_de = 1'b1; w_adv_back = 1'b1;
          end else begin
            w_adv_fd = 1'b1; w_adv_de = 1'b1; w_adv_back = 1'b1;
          end
        end
        ST_FLUSH: begin
          w_flush = 1'b1; w_adv_fd = 1'b1; w_adv_de = 1'b1; w_adv_back = 1'b1;
        end
        default: begin
          // MEM_WAIT: frozen, including the response cycle
        end
      endcase
    end
  end

  assign bus.adv_fd    = w_adv_fd;
  assign bus.adv_de    = w_adv_de;
  assign bus.adv_back  = w_adv_back;
  assign bus.bubble_de = w_bubble;
  assign bus.flush_fd  = w_flush;
  assign bus.flush_de  = w_flush;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

  // Sequencer state, pending redirect and performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_flush_pend <= 1'b0;
      r_live       <= 1'b0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_live <= 1'b1;
      if (r_live) begin
        case (r_state)
          ST_RUN: begin
            if (w_dmem_blk) begin
              r_state <= ST_MEM_WAIT;
              if (bus.ex_redirect) r_flush_pend <= 1'b1;
            end
          end
          ST_MEM_WAIT: begin
            if (bus.dmem_resp) begin
              // a redirect arriving on the response cycle is still owed a flush
              r_state      <= (r_flush_pend | bus.ex_redirect) ? ST_FLUSH : ST_RUN;
              r_flush_pend <= 1'b0;
            end else if (bus.ex_redirect) begin
              r_flush_pend <= 1'b1;
            end
          end
          default: r_state <= ST_RUN;
        endcase
        if (!w_adv_fd) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        if (w_flush)   r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  // Destination scoreboard shifts with the back end; x0 is never tracked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_v  <= 1'b0; r_ex_rd  <= '0; r_ex_ld <= 1'b0;
      r_mem_v <= 1'b0; r_mem_rd <= '0;
      r_wb_v  <= 1'b0; r_wb_rd  <= '0;
    end else if (w_adv_back) begin
      r_wb_v   <= r_mem_v;
      r_wb_rd  <= r_mem_rd;
      r_mem_v  <= r_ex_v;
      r_mem_rd <= r_ex_rd;
      if (w_adv_de && !w_bubble && !w_flush) begin
        r_ex_v  <= bus.dec_valid & bus.dec_rd_we & (bus.dec_rd != 5'd0);
        r_ex_rd <= bus.dec_rd;
        r_ex_ld <= bus.dec_is_load;
      end else begin
        r_ex_v  <= 1'b0;
        r_ex_rd <= '0;
        r_ex_ld <= 1'b0;
      end
    end
  end

endmodule
